id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock, clk (input, 1), rising-edge; reset rst (input, 1) SHALL be asynchronous and active-high.
REQ-002 id_valid  input  1  decode holds a valid instruction.
REQ-003 id_ready  output  1  ID/EX accepts the decode instruction this cycle.
REQ-004 id_pc, id_imm  input  32 each  decoded PC and sign-extended immediate.
REQ-005 id_rs1_src, id_rs2_src, id_rd_src  input  5 each  register indices.
REQ-006 id_rs1_val, id_rs2_val  input  32 each  register-file read data.
REQ-007 id_op  input  6  ALU opcode; id_we  input  1  writes rd; id_is_load  input  1  load instruction.
REQ-008 fwd_rs1_src, fwd_rs2_src  output  5 each  combinational copies of id_rs1_src/id_rs2_src, to the forwarding unit.
REQ-009 is_fwd_rs1, is_fwd_rs2  input  1 each; fwd_val  input  32  forwarding-unit result.
REQ-010 flush  input  1  taken branch/jump resolved in exec.
REQ-011 ex_ready  input  1  exec consumes the held instruction.
REQ-012 ex_valid  output  1; ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  output  32 each; ex_op  output  6; ex_rd_src  output  5; ex_we, ex_is_load  output  1 each -- registered ID/EX contents.

Function
REQ-013 Register SHALL advance when adv = ex_ready OR NOT ex_valid; otherwise all ex_* hold.
REQ-014 Transfer SHALL occur when id_valid AND id_ready; on advance without transfer, ex_valid SHALL load 0 (bubble), other ex_* don't-care.
REQ-015 id_ready SHALL equal adv AND NOT hazard, or 1 when flush is high.
REQ-016 Latency SHALL be one cycle: instruction accepted at edge N appears on ex_* after edge N.
REQ-017 Captured rs1 operand SHALL be fwd_val when is_fwd_rs1=1 and id_rs1_src!=0, else id_rs1_val; same for rs2 with is_fwd_rs2/id_rs2_src.
REQ-018 Source index 0 SHALL never match a hazard; captured x0 operand SHALL be 0 regardless of inputs.
REQ-019 Load-use hazard: ex_valid AND ex_is_load AND ex_we AND ex_rd_src!=0 AND ex_rd_src equals id_rs1_src or id_rs2_src -> hazard=1; exactly one bubble inserted, instruction issued next cycle.
REQ-020 flush SHALL override stall and transfer: on the edge with flush=1 and adv, ex_valid<=0 and the decode instruction is discarded (consumed, not issued).
REQ-021 flush with NOT adv SHALL still clear ex_valid to 0 (held instruction squashed).
REQ-022 Hazard SHALL be evaluated only when id_valid=1; otherwise hazard=0.
REQ-023 Register SHALL contain no combinational path from id_* to ex_*.

Reset
REQ-024 On rst: ex_valid=0, all other ex_* =0, internal history cleared; id_ready SHALL reflect cleared state (=1 absent flush-independent hazard).
REQ-025 Reset asserted mid-stall SHALL drop the held and stalled instructions; no bubble count carried over.

Configuration
REQ-026 Macro FWD_EN defined: behaviour per REQ-017/REQ-019 (forward, stall only on load-use).
REQ-027 FWD_EN undefined: is_fwd_*/fwd_val SHALL be ignored; operands from id_*_val only; block keeps a 3-entry history of issued rd (ex, mem, wb; valid AND we AND rd!=0), shifted on every clock, bubbles shift in empty.
REQ-028 FWD_EN undefined: hazard=1 while id_rs1_src or id_rs2_src matches any valid history entry; stall until cleared (max 3 cycles); flush SHALL clear the ex entry only.

Verification
REQ-029 FWD_EN: issue addi x5 (rs1_val=7), ex_ready=1 -> ex_valid=1, ex_rs1_val=7 one cycle later.
REQ-030 FWD_EN: is_fwd_rs1=1, fwd_val=0x1234, id_rs1_src=3, id_rs1_val=0 -> ex_rs1_val=0x1234; same with id_rs1_src=0 -> ex_rs1_val=0.
REQ-031 FWD_EN: lw x6 in EX, decode add x7,x6,x1 -> id_ready=0 one cycle, ex_valid=0 bubble, add issued next cycle.
REQ-032 Stall plus flush same cycle -> id_ready=1, ex_valid=0 next cycle, stalled instruction never issued.
REQ-033 No FWD_EN: add x5 issued, then sub x8,x5,x2 -> id_ready=0 for 3 cycles, sub issued on 4th.
REQ-034 ex_ready=0 for 4 cycles with held instruction -> all ex_* stable, id_ready=0; rst mid-hold -> ex_valid=0 immediately.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard stall, bubble and flush.
// FWD_EN: forwarded operands, load-use stall; else 3-deep rd scoreboard stall.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_src,
  input  logic [4:0]  id_rs2_src,
  input  logic [4:0]  id_rd_src,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic [5:0]  id_op,
  input  logic        id_we,
  input  logic        id_is_load,
  output logic [4:0]  fwd_rs1_src,
  output logic [4:0]  fwd_rs2_src,
  input  logic        is_fwd_rs1,
  input  logic        is_fwd_rs2,
  input  logic [31:0] fwd_val,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [5:0]  ex_op,
  output logic [4:0]  ex_rd_src,
  output logic        ex_we,
  output logic        ex_is_load
);

  logic        adv;
  logic        hazard;
  logic        xfer;
  logic [31:0] rs1_op;
  logic [31:0] rs2_op;

  assign fwd_rs1_src = id_rs1_src;
  assign fwd_rs2_src = id_rs2_src;

  assign adv      = ex_ready | ~ex_valid;
  assign id_ready = flush | (adv & ~hazard);
  // A flushed decode instruction is consumed but never issued.
  assign xfer     = id_valid & id_ready & ~flush;

`ifdef FWD_EN
  logic ld_hit;

  assign ld_hit = ex_valid & ex_is_load & ex_we
                & (ex_rd_src != 5'd0);

  always_comb begin
    hazard = 1'b0;
    if (id_valid && ld_hit)
      hazard = (ex_rd_src == id_rs1_src)
             | (ex_rd_src == id_rs2_src);
  end

  always_comb begin
    rs1_op = id_rs1_val;
    rs2_op = id_rs2_val;
    if (id_rs1_src == 5'd0)
      rs1_op = 32'd0;
    else if (is_fwd_rs1)
      rs1_op = fwd_val;
    if (id_rs2_src == 5'd0)
      rs2_op = 32'd0;
    else if (is_fwd_rs2)
      rs2_op = fwd_val;
  end
`else
  logic       unused_fwd;
  logic       ex_hv;
  logic       mem_hv;
  logic       wb_hv;
  logic [4:0] mem_rd;
  logic [4:0] wb_rd;
  logic       hit1;
  logic       hit2;

  assign unused_fwd = &{1'b0, is_fwd_rs1, is_fwd_rs2, fwd_val};

  // The ex slot of the history is the ID/EX register itself.
  assign ex_hv = ex_valid & ex_we & (ex_rd_src != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_hv <= 1'b0;
      mem_rd <= 5'd0;
      wb_hv  <= 1'b0;
      wb_rd  <= 5'd0;
    end else begin
      mem_hv <= ex_hv;
      mem_rd <= ex_rd_src;
      wb_hv  <= mem_hv;
      wb_rd  <= mem_rd;
    end
  end

  always_comb begin
    hit1 = (id_rs1_src != 5'd0)
         & ((ex_hv  & (ex_rd_src == id_rs1_src))
          | (mem_hv & (mem_rd    == id_rs1_src))
          | (wb_hv  & (wb_rd     == id_rs1_src)));
    hit2 = (id_rs2_src != 5'd0)
         & ((ex_hv  & (ex_rd_src == id_rs2_src))
          | (mem_hv & (mem_rd    == id_rs2_src))
          | (wb_hv  & (wb_rd     == id_rs2_src)));
    hazard = id_valid & (hit1 | hit2);
  end

  always_comb begin
    rs1_op = id_rs1_val;
    rs2_op = id_rs2_val;
    if (id_rs1_src == 5'd0)
      rs1_op = 32'd0;
    if (id_rs2_src == 5'd0)
      rs2_op = 32'd0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= 32'd0;
      ex_rs1_val <= 32'd0;
      ex_rs2_val <= 32'd0;
      ex_imm     <= 32'd0;
      ex_op      <= 6'd0;
      ex_rd_src  <= 5'd0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid <= xfer;
      if (xfer) begin
        ex_pc      <= id_pc;
        ex_rs1_val <= rs1_op;
        ex_rs2_val <= rs2_op;
        ex_imm     <= id_imm;
        ex_op      <= id_op;
        ex_rd_src  <= id_rd_src;
        ex_we      <= id_we;
        ex_is_load <= id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage.
// Covers the default build; FWD_EN adds forwarding and load-use vectors.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1_src;
  logic [4:0]  id_rs2_src;
  logic [4:0]  id_rd_src;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [5:0]  id_op;
  logic        id_we;
  logic        id_is_load;
  logic [4:0]  fwd_rs1_src;
  logic [4:0]  fwd_rs2_src;
  logic        is_fwd_rs1;
  logic        is_fwd_rs2;
  logic [31:0] fwd_val;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rd_src;
  logic        ex_we;
  logic        ex_is_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_src(id_rs1_src), .id_rs2_src(id_rs2_src),
    .id_rd_src(id_rd_src),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_op(id_op), .id_we(id_we), .id_is_load(id_is_load),
    .fwd_rs1_src(fwd_rs1_src), .fwd_rs2_src(fwd_rs2_src),
    .is_fwd_rs1(is_fwd_rs1), .is_fwd_rs2(is_fwd_rs2),
    .fwd_val(fwd_val), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_op(ex_op), .ex_rd_src(ex_rd_src),
    .ex_we(ex_we), .ex_is_load(ex_is_load)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] pc,
                       input logic [4:0] s1, s2, rd,
                       input logic [31:0] v1, v2,
                       input logic we, ld);
    id_valid   = v;
    id_pc      = pc;
    id_rs1_src = s1;
    id_rs2_src = s2;
    id_rd_src  = rd;
    id_rs1_val = v1;
    id_rs2_val = v2;
    id_we      = we;
    id_is_load = ld;
    id_op      = 6'h0a;
    id_imm     = 32'hffff_fff0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    is_fwd_rs1 = 1'b0;
    is_fwd_rs2 = 1'b0;
    fwd_val = 32'd0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_rd", {27'd0, ex_rd_src}, 32'd0);
    check("rst_ready", {31'd0, id_ready}, 32'd1);
    rst = 1'b0;

    // addi x5, x1, -16 with x1 = 7
    drive(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, 32'd7, 32'd0, 1'b1, 1'b0);
    #1;
    check("addi_ready", {31'd0, id_ready}, 32'd1);
    check("fwd_src1", {27'd0, fwd_rs1_src}, 32'd1);
    tick();
    check("addi_valid", {31'd0, ex_valid}, 32'd1);
    check("addi_rs1", ex_rs1_val, 32'd7);
    check("addi_pc", ex_pc, 32'h100);
    check("addi_rd", {27'd0, ex_rd_src}, 32'd5);
    check("addi_imm", ex_imm, 32'hffff_fff0);
    check("addi_op", {26'd0, ex_op}, 32'h0a);

`ifndef FWD_EN
    // sub x8, x5, x2 waits for x5 to leave ex, mem and wb
    drive(1'b1, 32'h104, 5'd5, 5'd2, 5'd8, 32'haa, 32'h22, 1'b1, 1'b0);
    #1;
    check("raw_c1_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("raw_bubble", {31'd0, ex_valid}, 32'd0);
    check("raw_c2_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("raw_c3_ready", {31'd0, id_ready}, 32'd0);
    tick();
    check("raw_c4_ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("raw_issue_valid", {31'd0, ex_valid}, 32'd1);
    check("raw_issue_pc", ex_pc, 32'h104);
    check("raw_issue_rs1", ex_rs1_val, 32'haa);
`else
    // add x8, x5, x2 is forwarded without a stall
    drive(1'b1, 32'h104, 5'd5, 5'd2, 5'd8, 32'haa, 32'h22, 1'b1, 1'b0);
    #1;
    check("fwd_nostall", {31'd0, id_ready}, 32'd1);
    drive(1'b1, 32'h104, 5'd3, 5'd2, 5'd8, 32'd0, 32'h22, 1'b1, 1'b0);
    is_fwd_rs1 = 1'b1;
    fwd_val = 32'h1234;
    tick();
    check("fwd_rs1", ex_rs1_val, 32'h1234);
    check("fwd_rs2", ex_rs2_val, 32'h22);
    is_fwd_rs1 = 1'b0;
    // lw x6 then add x7, x6, x1: one bubble
    drive(1'b1, 32'h110, 5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h114, 5'd6, 5'd1, 5'd7, 32'h66, 32'h11, 1'b1, 1'b0);
    #1;
    check("lu_ready0", {31'd0, id_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_ready1", {31'd0, id_ready}, 32'd1);
    tick();
    check("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_issue_rd", {27'd0, ex_rd_src}, 32'd7);
`endif

    // x0 operands read as zero even when forwarding is offered
    is_fwd_rs1 = 1'b1;
    is_fwd_rs2 = 1'b1;
    fwd_val = 32'h5555;
    drive(1'b1, 32'h108, 5'd0, 5'd0, 5'd0, 32'hdead, 32'hbeef, 1'b1, 1'b0);
    tick();
    check("x0_pc", ex_pc, 32'h108);
    check("x0_rs1", ex_rs1_val, 32'd0);
    check("x0_rs2", ex_rs2_val, 32'd0);
    is_fwd_rs1 = 1'b0;
    is_fwd_rs2 = 1'b0;

    // held instruction stays put while exec stalls
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 1'b1, 1'b0);
    tick();
    check("hold_load_pc", ex_pc, 32'h200);
    ex_ready = 1'b0;
    drive(1'b1, 32'h300, 5'd3, 5'd4, 5'd10, 32'h33, 32'h44, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_ready", {31'd0, id_ready}, 32'd0);
      tick();
      check("hold_valid", {31'd0, ex_valid}, 32'd1);
      check("hold_pc", ex_pc, 32'h200);
      check("hold_rs2", ex_rs2_val, 32'h22);
    end
    rst = 1'b1;
    #1;
    check("hold_rst_valid", {31'd0, ex_valid}, 32'd0);
    check("hold_rst_pc", ex_pc, 32'd0);
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    ex_ready = 1'b1;
    tick();
    rst = 1'b0;

    // lw x5 then stalled sub x8, x5, x3 flushed in the same cycle
    drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 1'b1, 1'b1);
    tick();
    check("lw_valid", {31'd0, ex_valid}, 32'd1);
    drive(1'b1, 32'h404, 5'd5, 5'd3, 5'd8, 32'd5, 32'd3, 1'b1, 1'b0);
    #1;
    check("stall_ready", {31'd0, id_ready}, 32'd0);
    flush = 1'b1;
    #1;
    check("flush_ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("flush_never", {31'd0, ex_valid}, 32'd0);

    // flush squashes a held instruction while exec is stalled
    drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 1'b1, 1'b0);
    tick();
    check("sq_load", {31'd0, ex_valid}, 32'd1);
    ex_ready = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    check("sq_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    ex_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
